layer_backward: RTL and testbench

- Backward pass of the fully-connected `layer` block, with the same Q8.8 format and flattened-vector layout.
- Takes upstream gradient dy (N_OUT), the forward input x (N_IN) and weights w (N_OUT x N_IN). Produces dx = W^T·dy, dw = dy·x^T and db = dy.
- Sequential: one (o,i) pair per cycle, two multipliers, start/done handshake. Sits after the forward layer in the training datapath.

---
 rtl/layer_backward.sv | 123 ++++++++++++
 tb/tb_layer_backward.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_backward.sv
// Backward pass of a Q8.8 fully-connected layer: dx = W^T*dy, dw = dy*x^T, db = dy.
// One (i,o) pair per cycle. Define LAYER_BWD_SAT_EN to saturate results instead of wrapping.
module layer_backward #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*N_IN-1:0]        x,
    input  logic [16*N_IN*N_OUT-1:0]  w,
    input  logic [16*N_OUT-1:0]       dy,
    output logic [16*N_IN-1:0]        dx,
    output logic [16*N_IN*N_OUT-1:0]  dw,
    output logic [16*N_OUT-1:0]       db,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W = 33 + $clog2(N_OUT);
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [16*N_IN-1:0]         xr;
    logic [16*N_IN*N_OUT-1:0]   wr;
    logic [16*N_OUT-1:0]        dyr;
    logic [IW-1:0]              i;
    logic [OW-1:0]              o;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [15:0]         x_sel;
    logic signed [15:0]         w_sel;
    logic signed [15:0]         dy_sel;
    logic signed [31:0]         p_dx;
    logic signed [31:0]         p_dw;
    int                         w_idx;

    // Floor shift to Q8.8, then narrow to 16 bits.
    function automatic logic [15:0] fmt(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 8;
`ifdef LAYER_BWD_SAT_EN
        if (s > ACC_W'(32767))
            fmt = 16'h7fff;
        else if (s < ACC_W'(-32768))
            fmt = 16'h8000;
        else
            fmt = s[15:0];
`else
        fmt = s[15:0];
`endif
    endfunction

    // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
    always_comb begin
        w_idx    = int'(o) * N_IN + int'(i);
        x_sel    = xr[int'(i)*16 +: 16];
        w_sel    = wr[w_idx*16 +: 16];
        dy_sel   = dyr[int'(o)*16 +: 16];
        p_dx     = w_sel * dy_sel;
        p_dw     = dy_sel * x_sel;
        acc_next = acc + ACC_W'(p_dx);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xr    <= '0;
            wr    <= '0;
            dyr   <= '0;
            i     <= '0;
            o     <= '0;
            acc   <= '0;
            dx    <= '0;
            dw    <= '0;
            db    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        xr    <= x;
                        wr    <= w;
                        dyr   <= dy;
                        db    <= dy;
                        i     <= '0;
                        o     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    dw[w_idx*16 +: 16] <= fmt(ACC_W'(p_dw));
                    if (o == OW'(N_OUT - 1)) begin
                        dx[int'(i)*16 +: 16] <= fmt(acc_next);
                        acc <= '0;
                        o   <= '0;
                        if (i == IW'(N_IN - 1)) begin
                            i     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        acc <= acc_next;
                        o   <= o + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_backward.sv
// Self-checking bench for layer_backward: directed spec cases plus random runs against
// an integer-arithmetic reference model. Honors LAYER_BWD_SAT_EN like the design.
module tb_layer_backward;

    localparam int NI = 2;
    localparam int NO = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [63:0] w;
    logic [31:0] dy;
    logic [31:0] dx;
    logic [63:0] dw;
    logic [31:0] db;
    logic        busy;
    logic        done;

    logic        start3;
    logic [47:0] x3;
    logic [47:0] w3;
    logic [15:0] dy3;
    logic [47:0] dx3;
    logic [47:0] dw3;
    logic [15:0] db3;
    logic        busy3;
    logic        done3;

    int tests_run = 0;
    int failures  = 0;

    layer_backward #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .dy(dy),
        .dx(dx), .dw(dw), .db(db), .busy(busy), .done(done)
    );

    layer_backward #(.N_IN(3), .N_OUT(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .x(x3), .w(w3), .dy(dy3),
        .dx(dx3), .dw(dw3), .db(db3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Q8.8 narrowing of an exact integer value.
    function automatic logic [15:0] fmt_m(input longint v);
        longint s;
        s = v >>> 8;
`ifdef LAYER_BWD_SAT_EN
        if (s > 32767) return 16'h7fff;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    // Matrix-level reference: dx(i) = sum_o w(o,i)*dy(o), dw(o,i) = dy(o)*x(i).
    function automatic void model(input logic [31:0] xv, input logic [63:0] wv, input logic [31:0] dyv,
                                  output logic [31:0] edx, output logic [63:0] edw);
        for (int ii = 0; ii < NI; ii++) begin
            longint sum;
            sum = 0;
            for (int oo = 0; oo < NO; oo++) begin
                longint wo, dyo, xi;
                wo  = longint'($signed(wv[(oo*NI+ii)*16 +: 16]));
                dyo = longint'($signed(dyv[oo*16 +: 16]));
                xi  = longint'($signed(xv[ii*16 +: 16]));
                sum += wo * dyo;
                edw[(oo*NI+ii)*16 +: 16] = fmt_m(dyo * xi);
            end
            edx[ii*16 +: 16] = fmt_m(sum);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then wait (bounded) for done; reports cycles to done and busy cycles seen.
    task automatic run(input logic [31:0] xv, input logic [63:0] wv, input logic [31:0] dyv,
                       output int cyc, output int bc);
        x = xv; w = wv; dy = dyv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        bc  = busy ? 1 : 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        x = '1; w = '1; dy = '1;
        tick(); tick();
        tests_run++;
        if ({dx, dw, db} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got dx=%h dw=%h db=%h, expected all 0", dx, dw, db);
        end
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b done=%b, expected 0 0", busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int cyc, bc;
        run({16'd512, 16'd256}, {16'd102, 16'd76, 16'd179, 16'd128}, {16'd128, 16'd256}, cyc, bc);
        tests_run++;
        if (cyc !== 4) begin failures++; $display("FAIL nominal_latency: got %0d expected 4", cyc); end
        tests_run++;
        if (bc !== 4) begin failures++; $display("FAIL nominal_busy_cycles: got %0d expected 4", bc); end
        tests_run++;
        if (dx !== {16'h00e6, 16'h00a6}) begin
            failures++; $display("FAIL nominal_dx: got %h expected %h", dx, {16'h00e6, 16'h00a6});
        end
        tests_run++;
        if (dw !== {16'd256, 16'd128, 16'd512, 16'd256}) begin
            failures++; $display("FAIL nominal_dw: got %h expected %h", dw, {16'd256, 16'd128, 16'd512, 16'd256});
        end
        tests_run++;
        if (db !== {16'd128, 16'd256}) begin
            failures++; $display("FAIL nominal_db: got %h expected %h", db, {16'd128, 16'd256});
        end
    endtask

    task automatic test_random();
        logic [31:0] xv, dyv, edx;
        logic [63:0] wv, edw;
        int cyc, bc;
        for (int n = 0; n < 8; n++) begin
            xv = $urandom; dyv = $urandom; wv = {$urandom, $urandom};
            if (n < 4) begin
                // Keep early runs within Q8.8 range so wrap and saturate agree.
                xv  = xv  & 32'h03ff_03ff;
                dyv = dyv & 32'h03ff_03ff;
                wv  = wv  & 64'h03ff_03ff_03ff_03ff;
            end
            model(xv, wv, dyv, edx, edw);
            run(xv, wv, dyv, cyc, bc);
            tests_run++;
            if (cyc !== 4) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected 4", n, cyc); end
            tests_run++;
            if (dx !== edx) begin failures++; $display("FAIL random_dx[%0d]: got %h expected %h", n, dx, edx); end
            tests_run++;
            if (dw !== edw) begin failures++; $display("FAIL random_dw[%0d]: got %h expected %h", n, dw, edw); end
            tests_run++;
            if (db !== dyv) begin failures++; $display("FAIL random_db[%0d]: got %h expected %h", n, db, dyv); end
        end
    endtask

    task automatic test_floor();
        logic [15:0] dy0 [3];
        logic [15:0] exp [3];
        int cyc, bc;
        dy0 = '{16'h0001, 16'hffff, 16'hff00};
        exp = '{16'h0000, 16'hffff, 16'hff80};
        for (int n = 0; n < 3; n++) begin
            run({16'h0000, 16'h0080}, 64'h0, {16'h0000, dy0[n]}, cyc, bc);
            tests_run++;
            if (dw[15:0] !== exp[n]) begin
                failures++; $display("FAIL floor_dw00[%0d]: got %h expected %h", n, dw[15:0], exp[n]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        int cyc, bc;
`ifdef LAYER_BWD_SAT_EN
        exp = 16'h7fff;
`else
        exp = 16'hfe00;
`endif
        run(32'h0, {4{16'h7fff}}, {2{16'h7fff}}, cyc, bc);
        tests_run++;
        if (dx !== {exp, exp}) begin
            failures++; $display("FAIL overflow_dx: got %h expected %h", dx, {exp, exp});
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] xv, dyv, edx;
        logic [63:0] wv, edw;
        int cyc;
        xv = $urandom & 32'h07ff_07ff; dyv = $urandom & 32'h07ff_07ff; wv = {$urandom, $urandom} & 64'h07ff_07ff_07ff_07ff;
        model(xv, wv, dyv, edx, edw);
        x = xv; w = wv; dy = dyv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        tick(); cyc++;
        x = ~xv; w = ~wv; dy = ~dyv; start = 1'b1;
        tick(); cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if (cyc !== 4) begin failures++; $display("FAIL ignore_start_latency: got %0d expected 4", cyc); end
        tests_run++;
        if ({dx, dw} !== {edx, edw}) begin
            failures++; $display("FAIL ignore_start_result: got %h %h expected %h %h", dx, dw, edx, edw);
        end
        tick(); tick();
        tests_run++;
        if (done !== 1'b1 || dx !== edx) begin
            failures++; $display("FAIL done_hold: got done=%b dx=%h expected 1 %h", done, dx, edx);
        end
    endtask

    task automatic test_mid_change();
        logic [31:0] xv, dyv, edx;
        logic [63:0] wv, edw;
        int cyc;
        xv = $urandom & 32'h07ff_07ff; dyv = $urandom & 32'h07ff_07ff; wv = {$urandom, $urandom} & 64'h07ff_07ff_07ff_07ff;
        model(xv, wv, dyv, edx, edw);
        x = xv; w = wv; dy = dyv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            x = $urandom; w = {$urandom, $urandom}; dy = $urandom;
            tick(); cyc++;
        end
        tests_run++;
        if ({dx, dw, db} !== {edx, edw, dyv}) begin
            failures++; $display("FAIL mid_change: got %h %h %h expected %h %h %h", dx, dw, db, edx, edw, dyv);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xv, dyv, edx;
        logic [63:0] wv, edw;
        int cyc;
        xv = $urandom & 32'h07ff_07ff; dyv = $urandom & 32'h07ff_07ff; wv = {$urandom, $urandom} & 64'h07ff_07ff_07ff_07ff;
        model(xv, wv, dyv, edx, edw);
        x = xv; w = wv; dy = dyv; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if ({busy, done} !== 2'b10) begin
            failures++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0", busy, done);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if (cyc !== 4 || {dx, dw, db} !== {edx, edw, dyv}) begin
            failures++; $display("FAIL b2b_result: got cyc=%0d %h %h %h expected 4 %h %h %h", cyc, dx, dw, db, edx, edw, dyv);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc;
        x = {16'd512, 16'd256}; w = {16'd102, 16'd76, 16'd179, 16'd128}; dy = {16'd128, 16'd256};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({dx, dw, db, busy, done} !== '0) begin
            failures++; $display("FAIL reset_mid: got dx=%h dw=%h db=%h busy=%b done=%b expected all 0", dx, dw, db, busy, done);
        end
        run({16'd512, 16'd256}, {16'd102, 16'd76, 16'd179, 16'd128}, {16'd128, 16'd256}, cyc, bc);
        tests_run++;
        if ({dx, dw, db} !== {32'h00e6_00a6, 64'h0100_0080_0200_0100, 32'h0080_0100}) begin
            failures++; $display("FAIL reset_mid_rerun: got %h %h %h expected 00e600a6 0100008002000100 00800100", dx, dw, db);
        end
    endtask

    task automatic test_sweep();
        int cyc;
        x3 = {16'd768, 16'd512, 16'd256}; w3 = {3{16'd256}}; dy3 = 16'd256;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        tests_run++;
        if (cyc !== 3) begin failures++; $display("FAIL sweep_latency: got %0d expected 3", cyc); end
        tests_run++;
        if (dx3 !== {3{16'h0100}}) begin failures++; $display("FAIL sweep_dx: got %h expected %h", dx3, {3{16'h0100}}); end
        tests_run++;
        if (dw3 !== {16'd768, 16'd512, 16'd256}) begin
            failures++; $display("FAIL sweep_dw: got %h expected %h", dw3, {16'd768, 16'd512, 16'd256});
        end
        tests_run++;
        if (db3 !== 16'h0100) begin failures++; $display("FAIL sweep_db: got %h expected 0100", db3); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_random();
        test_floor();
        test_overflow();
        test_ignore_start();
        test_mid_change();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
